sync_fifo_param: RTL

- Parametrised synchronous FIFO, next generation of the team's 8x18 FIFO.
- Generic width and depth; true full/empty flags and an occupancy count; programmable almost-full/almost-empty thresholds.
- Simultaneous read and write in one cycle; overflow/underflow error pulses.
- Sits between BCP datapath producers and consumers as the standard elastic buffer.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_ram.sv | 28 ++
 rtl/sync_fifo_param.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 18;
    localparam int FIFO_DEPTH_DEF  = 8;

    // Occupancy counter width: one extra bit so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Registered status flags, all derived from the next count or the current request.
    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic unf;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_param: one write port, one
// synchronous read port (read-before-write on an address collision).
// Contents are never reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write on we; registered read on re returns the value stored before this edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with count, full/empty, programmable
// almost-full/almost-empty thresholds and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise
// fifo_out is a registered read with one cycle of latency.
//
// Request semantics: with en=1, a read is accepted when the FIFO is not empty;
// a write is accepted when the FIFO is not full, or when it is full and a read
// is accepted in the same cycle. A rejected request raises overflow/underflow
// for exactly one cycle. With en=0 all requests are ignored and nothing moves.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   write,
    input  logic                   read,
    input  logic [DATA_W-1:0]      fifo_in,
    output logic [DATA_W-1:0]      fifo_out,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [ADDR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic              rd_acc, wr_acc;
    fifo_status_t      status_q, status_nxt;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              out_load;
    logic              out_valid_q;

    // Accept decisions, next pointers, next count and next flags.
    always_comb begin
        rd_acc     = en & read & ~status_q.empty;
        wr_acc     = en & write & (~status_q.full | rd_acc);
        rd_ptr_nxt = rd_acc ? rd_ptr + ADDR_W'(1) : rd_ptr;
        wr_ptr_nxt = wr_acc ? wr_ptr + ADDR_W'(1) : wr_ptr;
        cnt_nxt    = cnt_q;
        if (wr_acc && !rd_acc)      cnt_nxt = cnt_q + CNT_W'(1);
        else if (rd_acc && !wr_acc) cnt_nxt = cnt_q - CNT_W'(1);
        status_nxt.full   = (cnt_nxt == DEPTH_C);
        status_nxt.empty  = (cnt_nxt == '0);
        status_nxt.afull  = (cnt_nxt >= AFULL_C);
        status_nxt.aempty = (cnt_nxt <= AEMPTY_C);
        status_nxt.ovf    = en & write & ~wr_acc;
        status_nxt.unf    = en & read & ~rd_acc;
    end

    // Pointers, count and flags; reset wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
            status_q <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1,
                          ovf: 1'b0, unf: 1'b0};
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            cnt_q    <= cnt_nxt;
            status_q <= status_nxt;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The head is reloaded whenever the FIFO stays non-empty. If the new head
    // is the word being written at this edge, the RAM cannot return it yet,
    // so it is captured from fifo_in instead.
    logic              bypass;
    logic              use_byp_q;
    logic [DATA_W-1:0] byp_q;

    always_comb begin
        out_load  = en & (cnt_nxt != '0);
        bypass    = wr_acc & (wr_ptr == rd_ptr_nxt);
        ram_re    = out_load & ~bypass & ~rst;
        ram_raddr = rd_ptr_nxt;
    end

    // Bypass capture of a word that becomes the head on the edge it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            use_byp_q <= 1'b0;
        end else if (out_load) begin
            use_byp_q <= bypass;
            if (bypass) byp_q <= fifo_in;
        end
    end

    assign fifo_out = !out_valid_q ? '0 : (use_byp_q ? byp_q : ram_rdata);
`else
    // Registered read: the word at rd_ptr is fetched on the accepting edge.
    always_comb begin
        out_load  = rd_acc;
        ram_re    = rd_acc & ~rst;
        ram_raddr = rd_ptr;
    end

    assign fifo_out = out_valid_q ? ram_rdata : '0;
`endif

    // Marks that the RAM read register holds a real word; forces fifo_out to 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) out_valid_q <= 1'b0;
        else if (out_load) out_valid_q <= 1'b1;
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr),
        .wdata (fifo_in),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign fifo_count   = cnt_q;
    assign fifo_full    = status_q.full;
    assign fifo_empty   = status_q.empty;
    assign almost_full  = status_q.afull;
    assign almost_empty = status_q.aempty;
    assign overflow     = status_q.ovf;
    assign underflow    = status_q.unf;

endmodule
